burst_memory: RTL and testbench
===============================

Name: burst_memory

Overview:
Parametrised successor to the single-beat valid/ready memory. A single-port synchronous RAM that accepts one command, either read or write, of 1..MAX_BURST beats. The command handshake is separate from the data beats, and the block supports incrementing (INCR) and aligned wrapping (WRAP) address modes with a range/legality error response. It sits behind a bus master or DMA engine as local storage.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 32, number of words; must be a power of two
ADDR_WIDTH, $clog2(DEPTH), address width
MAX_BURST, 8, maximum beats per command; a power of two, ≤ DEPTH
LEN_WIDTH, $clog2(MAX_BURST), width of len field (beats minus 1)

Ports:
clk  input  1  single clock; all logic on posedge
rst  input  1  synchronous, active-high reset
valid  input  1  command valid
ready  output  1  command accept; high only in IDLE
wr_rd  input  1  1 = write burst, 0 = read burst
addr  input  ADDR_WIDTH  start address
len  input  LEN_WIDTH  beats minus 1
wrap  input  1  0 = INCR, 1 = WRAP
wdata  input  WIDTH  write beat data
wvalid  input  1  write beat valid
wready  output  1  write beat accept; high only in WRITE
rdata  output  WIDTH  read beat data (registered)
rvalid  output  1  read beat valid
rlast  output  1  high with final read beat
done  output  1  one-cycle pulse, command complete
err  output  1  high with done when command rejected

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: ready=0 during rst, 1 in first cycle after release. wready, rvalid, rlast, done, err = 0; rdata = 0.
- Reset clears all DEPTH words to 0.
- Reset mid-burst aborts the command. No done pulse is generated; FSM returns to IDLE.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE: ready=1. Accept on a posedge with valid&&ready. Latch addr, len, wrap and wr_rd.
  - Legality check at accept:
    - INCR: addr+len (ADDR_WIDTH+1 bits) > DEPTH-1 is illegal.
    - WRAP: len+1 not a power of two is illegal.
  - Illegal command → RESP with err.
  - Legal write → WRITE; legal read → READ.
- Commands presented while ready=0 are ignored, not queued.
- WRITE: wready=1. On each posedge with wvalid=1, mem[cur]<=wdata and advance cur.
  - wvalid=0 stalls indefinitely; there is no timeout.
  - After beat len+1 is written → RESP.
  - wvalid outside WRITE is ignored.
- READ: no backpressure; one address is issued per cycle for len+1 cycles.
  - rdata/rvalid register the read, so beat k (k=0..len) appears one cycle after its address is issued.
  - The first rvalid is in the 2nd cycle after the accept edge. Beats are contiguous.
  - rlast coincides with beat len.
  - State → RESP in the cycle after the last address is issued; done aligns with the cycle after rlast.
- RESP: one cycle, done=1, err=1 only for an illegal command. Then → IDLE.
  - An accepted-to-next-ready gap is at least 2 cycles.
- Address generation:
  - INCR: cur+1.
  - WRAP: base = start & ~len (zero-extended); next = base | ((cur+1) & len).
  - Example: start 6, len 3 → 6, 7, 4, 5.
- Illegal commands perform no memory access and produce no rvalid or wready.
- Read-during-write: not possible, since the memory is single-command.
- rdata holds its last value when rvalid=0.

Test Plan:
1. Reset: rst high for 2 cycles, then read addr 5 len 0 INCR → ready=1 after release; single beat rdata=0x00 with rvalid=rlast=1; done 1 cycle later, err=0.
2. INCR write addr 4 len 3, data 0x33, 0x35, 0x37, 0x39, with wvalid low for 2 cycles after the 2nd beat → wready held 1, done pulse after the 4th beat. Read back addr 4 len 3 → 0x33, 0x35, 0x37, 0x39 on consecutive cycles, rlast on 0x39.
3. WRAP write addr 6 len 3, data 0xA1, 0xA3, 0xA5, 0xA7 → INCR read addr 4 len 3 returns 0xA5, 0xA7, 0xA1, 0xA3.
4. INCR write addr 30 len 3 → err=done=1 for 1 cycle, wready never 1; read 30 len 1 returns previous contents (0x00, 0x00). WRAP read len 2 → err=1, no rvalid.
5. Assert valid with a new command during a READ burst → ignored; only the original beats appear. Then rst during the 2nd beat of an 8-beat read → rvalid=0 next cycle, no done, memory reads back 0.

Source files
------------

// File: rtl/burst_memory_if.sv
// Command, write-beat and read-beat signals of the burst memory.
interface burst_memory_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int LEN_WIDTH  = 3
);
    logic                  valid;
    logic                  ready;
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic                  wrap;
    logic [WIDTH-1:0]      wdata;
    logic                  wvalid;
    logic                  wready;
    logic [WIDTH-1:0]      rdata;
    logic                  rvalid;
    logic                  rlast;
    logic                  done;
    logic                  err;

    modport master (
        output valid, wr_rd, addr, len, wrap, wdata, wvalid,
        input  ready, wready, rdata, rvalid, rlast, done, err
    );

    modport slave (
        input  valid, wr_rd, addr, len, wrap, wdata, wvalid,
        output ready, wready, rdata, rvalid, rlast, done, err
    );
endinterface

// File: rtl/burst_memory.sv
// Single-port synchronous RAM serving one INCR/WRAP burst command at a time.
module burst_memory #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int MAX_BURST  = 8,
    parameter int LEN_WIDTH  = $clog2(MAX_BURST)
) (
    input  logic          clk,
    input  logic          rst,
    burst_memory_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  wrap_q, wrap_d;
    logic                  bad_q, bad_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [WIDTH-1:0]      mem_q [DEPTH];

    logic                  mem_we;
    logic                  rd_issue;
    logic                  cmd_illegal;
    logic                  last_beat;
    logic [ADDR_WIDTH:0]   incr_end;
    logic [LEN_WIDTH:0]    len_p1;
    logic [ADDR_WIDTH-1:0] len_ext;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign bus.ready  = (state_q == IDLE) && !rst;
    assign bus.wready = (state_q == WRITE);
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rlast  = rlast_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;

    // Legality of the presented command and next burst address
    always_comb begin
        incr_end    = {1'b0, bus.addr} + (ADDR_WIDTH+1)'(bus.len);
        len_p1      = {1'b0, bus.len} + (LEN_WIDTH+1)'(1);
        cmd_illegal = bus.wrap ? ((len_p1 & {1'b0, bus.len}) != '0)
                               : (incr_end > (ADDR_WIDTH+1)'(DEPTH - 1));
        len_ext     = ADDR_WIDTH'(len_q);
        last_beat   = (cnt_q == len_q);
        // wrap stays inside the len+1 aligned block containing the start address
        next_addr   = wrap_q ? ((start_q & ~len_ext) | ((cur_q + ADDR_WIDTH'(1)) & len_ext))
                             : (cur_q + ADDR_WIDTH'(1));
    end

    // Next-state, datapath controls and registered output values
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        cur_d    = cur_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        wrap_d   = wrap_q;
        bad_d    = bad_q;
        mem_we   = 1'b0;
        rd_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    start_d = bus.addr;
                    cur_d   = bus.addr;
                    len_d   = bus.len;
                    wrap_d  = bus.wrap;
                    cnt_d   = '0;
                    bad_d   = cmd_illegal;
                    if (cmd_illegal)    state_d = RESP;
                    else if (bus.wr_rd) state_d = WRITE;
                    else                state_d = READ;
                end
            end
            WRITE: begin
                if (bus.wvalid) begin
                    mem_we = 1'b1;
                    cur_d  = next_addr;
                    cnt_d  = cnt_q + LEN_WIDTH'(1);
                    if (last_beat) state_d = RESP;
                end
            end
            READ: begin
                rd_issue = 1'b1;
                cur_d    = next_addr;
                cnt_d    = cnt_q + LEN_WIDTH'(1);
                if (last_beat) state_d = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rdata_d  = rd_issue ? mem_q[cur_q] : rdata_q;
        rvalid_d = rd_issue;
        rlast_d  = rd_issue && last_beat;
        done_d   = (state_q == RESP);
        err_d    = (state_q == RESP) && bad_q;
    end

    // Control and read-output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= '0;
            cur_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
            bad_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            cur_q    <= cur_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
            bad_q    <= bad_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Storage array, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[cur_q] <= bus.wdata;
        end
    end

endmodule

// File: tb/tb_burst_memory.sv
// Randomised and directed bench for burst_memory with a cycle-scheduled model.
module tb_burst_memory;
    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int MAXB  = 8;
    localparam int LW    = 3;
    localparam int MAXC  = 4000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    burst_memory_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    burst_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per cycle, filled in when a command is scheduled
    bit         exp_ready  [MAXC];
    bit         exp_wready [MAXC];
    bit         exp_rvalid [MAXC];
    bit         exp_rlast  [MAXC];
    bit         exp_done   [MAXC];
    bit         exp_err    [MAXC];
    bit         exp_zero   [MAXC];
    logic [7:0] exp_rdata  [MAXC];

    logic [7:0] mdl_mem [DEPTH];
    int         free_at;
    int         tests = 0;
    int         fails = 0;
    bit         chk_on = 0;
    logic [7:0] hold = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    // Compare every output against the schedule on each falling edge
    always @(negedge clk) begin
        if (chk_on && cyc >= 1 && cyc < MAXC) begin
            if (exp_zero[cyc])   hold = '0;
            if (exp_rvalid[cyc]) hold = exp_rdata[cyc];
            chk("ready",  32'(bus.ready),  32'(exp_ready[cyc]));
            chk("wready", 32'(bus.wready), 32'(exp_wready[cyc]));
            chk("rvalid", 32'(bus.rvalid), 32'(exp_rvalid[cyc]));
            chk("rlast",  32'(bus.rlast),  32'(exp_rlast[cyc]));
            chk("done",   32'(bus.done),   32'(exp_done[cyc]));
            chk("err",    32'(bus.err),    32'(exp_err[cyc]));
            chk("rdata",  32'(bus.rdata),  32'(hold));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_from(input int c0);
        for (int c = c0; c < MAXC; c++) begin
            exp_ready[c]  = 1'b1;
            exp_wready[c] = 1'b0;
            exp_rvalid[c] = 1'b0;
            exp_rlast[c]  = 1'b0;
            exp_done[c]   = 1'b0;
            exp_err[c]    = 1'b0;
            exp_zero[c]   = 1'b0;
            exp_rdata[c]  = '0;
        end
    endtask

    // Drive rst in the current cycle and hold it for k cycles
    task automatic do_reset(input int k);
        int r;
        r = cyc;
        rst = 1'b1;
        bus.valid  = 1'b0;
        bus.wvalid = 1'b0;
        clear_from(r + 1);
        for (int c = r; c < r + k; c++) exp_ready[c] = 1'b0;
        exp_zero[r + 1] = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        repeat (k) step();
        rst = 1'b0;
        free_at = cyc;
    endtask

    // Issue one command once the model says the memory is idle
    task automatic send_cmd(input bit wr, input int a, input int l, input bit wrp,
                            input bit junk_busy, input int stall_beat, input int stall_len,
                            input bit rnd_stall, input logic [7:0] wd [8], output int n_out);
        int  n;
        int  ad [8];
        int  base;
        int  stalls;
        bit  ok;
        while (cyc < free_at) begin
            if (junk_busy) begin
                bus.valid = 1'b1;
                bus.wr_rd = 1'($urandom);
                bus.addr  = AW'($urandom);
                bus.len   = LW'($urandom);
                bus.wrap  = 1'($urandom);
            end else begin
                bus.valid = 1'b0;
            end
            step();
        end
        n = cyc;
        n_out = n;
        bus.valid  = 1'b1;
        bus.wr_rd  = wr;
        bus.addr   = AW'(a);
        bus.len    = LW'(l);
        bus.wrap   = wrp;
        bus.wvalid = 1'b0;
        ok = wrp ? ($countones(l + 1) == 1) : (a + l <= DEPTH - 1);
        base = a - (a % (l + 1));
        for (int k = 0; k < 8; k++)
            ad[k] = wrp ? base + ((a - base + k) % (l + 1)) : (a + k) % DEPTH;
        step();
        bus.valid = 1'b0;
        if (!ok) begin
            exp_ready[n + 1] = 1'b0;
            exp_done[n + 2]  = 1'b1;
            exp_err[n + 2]   = 1'b1;
            free_at = n + 2;
            if (wr) begin
                bus.wvalid = 1'b1;
                bus.wdata  = 8'hEE;
            end
        end else if (!wr) begin
            for (int c = n + 1; c <= n + 2 + l; c++) exp_ready[c] = 1'b0;
            for (int k = 0; k <= l; k++) begin
                exp_rvalid[n + 2 + k] = 1'b1;
                exp_rdata[n + 2 + k]  = mdl_mem[ad[k]];
                exp_rlast[n + 2 + k]  = (k == l);
            end
            exp_done[n + 3 + l] = 1'b1;
            free_at = n + 3 + l;
        end else begin
            for (int k = 0; k <= l; k++) begin
                if (rnd_stall) stalls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                else           stalls = (k == stall_beat) ? stall_len : 0;
                repeat (stalls) begin
                    bus.wvalid = 1'b0;
                    bus.wdata  = 8'($urandom);
                    exp_ready[cyc]  = 1'b0;
                    exp_wready[cyc] = 1'b1;
                    step();
                end
                bus.wvalid = 1'b1;
                bus.wdata  = wd[k];
                exp_ready[cyc]  = 1'b0;
                exp_wready[cyc] = 1'b1;
                mdl_mem[ad[k]]  = wd[k];
                step();
            end
            bus.wvalid = 1'b0;
            exp_ready[cyc]    = 1'b0;
            exp_done[cyc + 1] = 1'b1;
            free_at = cyc + 1;
        end
    endtask

    initial begin
        logic [7:0] wd [8];
        int n;
        int l;
        bit wrp;
        rst        = 1'b1;
        bus.valid  = 1'b0;
        bus.wr_rd  = 1'b0;
        bus.addr   = '0;
        bus.len    = '0;
        bus.wrap   = 1'b0;
        bus.wdata  = '0;
        bus.wvalid = 1'b0;
        for (int k = 0; k < 8; k++) wd[k] = '0;
        clear_from(0);
        chk_on = 1'b1;
        do_reset(2);

        // 1: single-beat read of cleared memory
        send_cmd(1'b0, 5, 0, 1'b0, 1'b0, 0, 0, 1'b0, wd, n);
        chk("pin_t1_rdata", 32'(exp_rdata[n + 2]), 32'h00);
        chk("pin_t1_rlast", 32'(exp_rlast[n + 2]), 32'd1);
        chk("pin_t1_done",  32'(exp_done[n + 3]),  32'd1);

        // 2: INCR write with a two-cycle stall after the second beat, read back
        wd[0] = 8'h33; wd[1] = 8'h35; wd[2] = 8'h37; wd[3] = 8'h39;
        send_cmd(1'b1, 4, 3, 1'b0, 1'b0, 2, 2, 1'b0, wd, n);
        send_cmd(1'b0, 4, 3, 1'b0, 1'b0, 0, 0, 1'b0, wd, n);
        chk("pin_t2_b0", 32'(exp_rdata[n + 2]), 32'h33);
        chk("pin_t2_b3", 32'(exp_rdata[n + 5]), 32'h39);
        chk("pin_t2_last", 32'(exp_rlast[n + 5]), 32'd1);

        // 3: WRAP write from 6 lands on 6,7,4,5
        wd[0] = 8'hA1; wd[1] = 8'hA3; wd[2] = 8'hA5; wd[3] = 8'hA7;
        send_cmd(1'b1, 6, 3, 1'b1, 1'b0, 0, 0, 1'b0, wd, n);
        send_cmd(1'b0, 4, 3, 1'b0, 1'b0, 0, 0, 1'b0, wd, n);
        chk("pin_t3_b0", 32'(exp_rdata[n + 2]), 32'hA5);
        chk("pin_t3_b1", 32'(exp_rdata[n + 3]), 32'hA7);
        chk("pin_t3_b2", 32'(exp_rdata[n + 4]), 32'hA1);
        chk("pin_t3_b3", 32'(exp_rdata[n + 5]), 32'hA3);

        // 4: out-of-range INCR write, then an illegal WRAP length
        wd[0] = 8'h55; wd[1] = 8'h66;
        send_cmd(1'b1, 30, 3, 1'b0, 1'b0, 0, 0, 1'b0, wd, n);
        chk("pin_t4_err", 32'(exp_err[n + 2]), 32'd1);
        send_cmd(1'b0, 30, 1, 1'b0, 1'b0, 0, 0, 1'b0, wd, n);
        chk("pin_t4_rd", 32'(exp_rdata[n + 3]), 32'h00);
        send_cmd(1'b0, 8, 2, 1'b1, 1'b0, 0, 0, 1'b0, wd, n);
        chk("pin_t4_wrap_err", 32'(exp_err[n + 2]), 32'd1);

        // 5: commands during a read are ignored; reset aborts an 8-beat read
        for (int k = 0; k < 8; k++) wd[k] = 8'(8'h10 + k);
        send_cmd(1'b1, 0, 7, 1'b0, 1'b0, 0, 0, 1'b0, wd, n);
        send_cmd(1'b0, 0, 7, 1'b0, 1'b0, 0, 0, 1'b0, wd, n);
        send_cmd(1'b0, 8, 3, 1'b0, 1'b1, 0, 0, 1'b0, wd, n);
        send_cmd(1'b0, 0, 7, 1'b0, 1'b1, 0, 0, 1'b0, wd, n);
        step();
        step();
        do_reset(2);
        send_cmd(1'b0, 0, 7, 1'b0, 1'b0, 0, 0, 1'b0, wd, n);
        chk("pin_t5_zero", 32'(exp_rdata[n + 2]), 32'h00);

        // Random commands with stalls, idle gaps and nuisance inputs
        for (int i = 0; i < 60; i++) begin
            if (cyc > MAXC - 120) break;
            repeat ($urandom_range(0, 2)) begin
                bus.wvalid = 1'($urandom);
                bus.wdata  = 8'($urandom);
                step();
            end
            for (int k = 0; k < 8; k++) wd[k] = 8'($urandom);
            wrp = ($urandom_range(0, 2) == 0);
            if (wrp && $urandom_range(0, 4) != 0) begin
                case ($urandom_range(0, 3))
                    0: l = 0;
                    1: l = 1;
                    2: l = 3;
                    default: l = 7;
                endcase
            end else begin
                l = int'($urandom_range(0, 7));
            end
            send_cmd(1'($urandom), int'($urandom_range(0, DEPTH - 1)), l, wrp,
                     1'($urandom), 0, 0, 1'b1, wd, n);
        end

        // Final sweep of the whole array
        for (int a = 0; a < DEPTH; a += 8)
            send_cmd(1'b0, a, 7, 1'b0, 1'b0, 0, 0, 1'b0, wd, n);
        while (cyc < free_at + 2) step();
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
